// File: rtl/alu_op_sequencer.sv
// rtl/alu_op_sequencer.sv - command/response sequencer driving a combinational ALU, with sticky NZCV flags
// Optional feature macro: ALU_SEQ_FWD_EN (adds cmd_fwd and a last-result forwarding register onto alu_a)
module alu_op_sequencer #(
  parameter int DATA_W = 64,
  parameter int SEL_W  = 5,
  parameter int SETTLE = 1
) (
  input  logic              clock,
  input  logic              reset_n,
  input  logic              cmd_valid,
  output logic              cmd_ready,
  input  logic [DATA_W-1:0] cmd_a,
  input  logic [DATA_W-1:0] cmd_b,
  input  logic [SEL_W-1:0]  cmd_sel,
  input  logic              cmd_cin,
  input  logic              cmd_setf,
`ifdef ALU_SEQ_FWD_EN
  input  logic              cmd_fwd,
`endif
  output logic [DATA_W-1:0] alu_a,
  output logic [DATA_W-1:0] alu_b,
  output logic [SEL_W-1:0]  alu_sel,
  output logic [1:0]        alu_cin,
  input  logic [DATA_W-1:0] alu_out,
  input  logic [1:0]        alu_cout,
  input  logic [3:0]        alu_status,
  output logic              rsp_valid,
  input  logic              rsp_ready,
  output logic [DATA_W-1:0] rsp_data,
  output logic [1:0]        rsp_cout,
  output logic [3:0]        rsp_status,
  output logic [3:0]        flags,
  output logic              busy
);

  // A settle time of zero cannot be honoured by a registered capture, so clamp to one cycle.
  localparam int SETTLE_EFF = (SETTLE < 1) ? 1 : SETTLE;
  localparam int CNT_W      = (SETTLE_EFF > 1) ? $clog2(SETTLE_EFF) : 1;
  localparam logic [CNT_W-1:0] CNT_LOAD = CNT_W'(SETTLE_EFF - 1);

  typedef enum logic [1:0] {
    S_IDLE   = 2'd0,
    S_SETTLE = 2'd1,
    S_RESP   = 2'd2
  } state_t;

  state_t            state_q;
  logic [CNT_W-1:0]  cnt_q;
  logic [CNT_W-1:0]  cnt_d;
  logic              setf_q;
  logic              cmd_ready_q;
  logic              busy_q;
  logic              rsp_valid_q;
  logic [DATA_W-1:0] alu_a_q;
  logic [DATA_W-1:0] alu_b_q;
  logic [SEL_W-1:0]  alu_sel_q;
  logic [1:0]        alu_cin_q;
  logic [DATA_W-1:0] rsp_data_q;
  logic [1:0]        rsp_cout_q;
  logic [3:0]        rsp_status_q;
  logic [3:0]        flags_q;
  logic [DATA_W-1:0] a_src;

`ifdef ALU_SEQ_FWD_EN
  logic [DATA_W-1:0] last_q;

  // Chained ops take operand A from the previous captured result instead of the command.
  always_comb begin
    a_src = cmd_fwd ? last_q : cmd_a;
  end

  // Last-result register follows every capture so the next op can chain on it.
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      last_q <= '0;
    end else if (state_q == S_SETTLE && cnt_q == '0) begin
      last_q <= alu_out;
    end
  end
`else
  // Without forwarding, operand A always comes straight from the command.
  always_comb begin
    a_src = cmd_a;
  end
`endif

  // Settle countdown step used while waiting for the ALU outputs to become valid.
  always_comb begin
    cnt_d = cnt_q - 1'b1;
  end

  // Sequencer FSM: accept, hold ALU inputs for the settle time, capture, then hand off the response.
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      state_q      <= S_IDLE;
      cnt_q        <= '0;
      setf_q       <= 1'b0;
      cmd_ready_q  <= 1'b1;
      busy_q       <= 1'b0;
      rsp_valid_q  <= 1'b0;
      alu_a_q      <= '0;
      alu_b_q      <= '0;
      alu_sel_q    <= '0;
      alu_cin_q    <= '0;
      rsp_data_q   <= '0;
      rsp_cout_q   <= '0;
      rsp_status_q <= '0;
      flags_q      <= '0;
    end else begin
      case (state_q)
        S_IDLE: begin
          if (cmd_valid) begin
            alu_a_q     <= a_src;
            alu_b_q     <= cmd_b;
            alu_sel_q   <= cmd_sel;
            alu_cin_q   <= {1'b0, cmd_cin};
            setf_q      <= cmd_setf;
            cnt_q       <= CNT_LOAD;
            cmd_ready_q <= 1'b0;
            busy_q      <= 1'b1;
            state_q     <= S_SETTLE;
          end
        end
        S_SETTLE: begin
          if (cnt_q == '0) begin
            rsp_data_q   <= alu_out;
            rsp_cout_q   <= alu_cout;
            rsp_status_q <= alu_status;
            if (setf_q) begin
              flags_q <= alu_status;
            end
            rsp_valid_q <= 1'b1;
            state_q     <= S_RESP;
          end else begin
            cnt_q <= cnt_d;
          end
        end
        S_RESP: begin
          if (rsp_ready) begin
            rsp_valid_q <= 1'b0;
            cmd_ready_q <= 1'b1;
            busy_q      <= 1'b0;
            state_q     <= S_IDLE;
          end
        end
        default: begin
          rsp_valid_q <= 1'b0;
          cmd_ready_q <= 1'b1;
          busy_q      <= 1'b0;
          state_q     <= S_IDLE;
        end
      endcase
    end
  end

  assign cmd_ready  = cmd_ready_q;
  assign busy       = busy_q;
  assign rsp_valid  = rsp_valid_q;
  assign alu_a      = alu_a_q;
  assign alu_b      = alu_b_q;
  assign alu_sel    = alu_sel_q;
  assign alu_cin    = alu_cin_q;
  assign rsp_data   = rsp_data_q;
  assign rsp_cout   = rsp_cout_q;
  assign rsp_status = rsp_status_q;
  assign flags      = flags_q;

endmodule
